data_c_shift_arbiter: RTL and testbench
=======================================

Name: data_c_shift_arbiter

Overview:
- Shares one `data_c_pipe_inf_right_shift` instance between NUM packet requesters.
- Grants the pipe packet-by-packet in round-robin order and tags every beat with {last, id} on the pipe's ex sideband.
- Appends one zero flush beat per packet so shifted residue never leaks between packets.
- Steers returning pipe beats to the owning requester by the returned id.

Parameters:
- NUM, 4, number of requesters (2..16).
- DSIZE, 8, data width of requesters and pipe.
- IDSIZE, $clog2(NUM), requester id width.
- EX_SIZE, IDSIZE+1, pipe ex width; layout {last, id}.

Ports:
- clock  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- s_valid  in  NUM  requester beat valid.
- s_data  in  NUM*DSIZE  requester data; requester i at [i*DSIZE +: DSIZE].
- s_last  in  NUM  final beat of requester packet.
- s_ready  out  NUM  requester ready.
- p_valid  out  1  to pipe slaver.valid.
- p_data  out  DSIZE  to pipe slaver.data.
- p_ex  out  EX_SIZE  to pipe ex_in.
- p_ready  in  1  from pipe slaver.ready.
- r_valid  in  1  from pipe master.valid.
- r_data  in  DSIZE  from pipe master.data.
- r_ex  in  EX_SIZE  from pipe ex_out.
- r_ready  out  1  to pipe master.ready.
- m_valid  out  NUM  per-requester result valid.
- m_data  out  DSIZE  result data, broadcast to all requesters.
- m_last  out  1  result beat is the packet's final (flush) beat.
- m_ready  in  NUM  per-requester result ready.
- busy  out  1  grant or flush in progress.
- cur_id  out  IDSIZE  currently granted requester.

Behaviour:
- Interface decision: one clock, `clock`. Reset `rst` is asynchronous and active-high.
- Reset values:
  - state = IDLE; rr_ptr = NUM-1, so the first grant goes to id 0; cur_id = 0; busy = 0.
  - All s_ready, p_valid, m_valid = 0; p_data = 0, p_ex = 0.
  - Reset mid-packet discards the grant; the downstream pipe shares the reset.
- FSM, state and cur_id registered:
  - IDLE: busy = 0, p_valid = 0.
    - If any s_valid: cur_id <= first asserted requester searching rr_ptr+1, rr_ptr+2, ... modulo NUM; rr_ptr <= that id; next = GRANT.
    - Else stay in IDLE.
    - Arbitration costs exactly 1 cycle.
  - GRANT: busy = 1.
    - p_valid = s_valid[cur_id]; p_data = s_data[cur_id]; p_ex = {1'b0, cur_id}.
    - s_ready[cur_id] = p_ready; all other s_ready = 0.
    - Handshake with s_last[cur_id] = 1: next = FLUSH.
    - Otherwise stay in GRANT, including while s_valid drops mid-packet (packet lock, no timeout).
  - FLUSH: busy = 1; p_valid = 1; p_data = 0; p_ex = {1'b1, cur_id}; all s_ready = 0.
    - On p_ready: next = IDLE. Otherwise hold all FLUSH outputs stable.
- p_* and s_ready are combinational from state and inputs. No data register in the forward path; zero added latency beyond the pipe.
- Single-beat packet (s_last on first beat): sequence is GRANT for 1 beat, then FLUSH, then IDLE.
- Round robin: a requester re-requesting right after its own packet is served only after every other asserted requester has had one packet.
- Return path, fully combinational:
  - m_valid[i] = r_valid && (r_ex[IDSIZE-1:0] == i).
  - r_ready = m_ready[r_ex id].
  - m_data = r_data; m_last = r_ex[IDSIZE].
- Return beats per packet = input beats + 1. The last return beat is the flush result, carrying the final residue bits.
- The next packet's first beat shifts in the zero residue left by the flush.
- r_ex id >= NUM (unreachable when NUM is a power of two): r_ready = 0, stall. This is an assertion target.
- Assertions:
  - p_valid stays high until p_ready.
  - At most one s_ready bit high at any time.

Test Plan:
- Basic packet, NUM=4, pipe SHIFT_BITS=1. Requester 0 sends 0x81, 0x02(last).
  - Required: pipe inputs 0x81, 0x02, 0x00 with ex 0x0, 0x0, 0x4.
  - Required: m_valid[0] beats 0x40, 0x81, 0x00(m_last).
- Round robin. After reset, requesters 1, 2, 3 each hold one 1-beat packet.
  - Required: grant order 1, 2, 3.
  - Then 0 and 3 request together: 0 is granted before 3.
- Flush backpressure. Hold p_ready=0 for 5 cycles during FLUSH.
  - Required: p_valid=1, p_data=0, p_ex={1, id} stable; no other s_ready asserted.
- Output routing backpressure. Requester 2 packet returning with m_ready[2]=0.
  - Required: r_ready=0, pipe stalls, m_valid[2] held; all other m_valid=0.
- Mid-packet idle. Requester 1 drops s_valid for 3 cycles between beats.
  - Required: grant retained, cur_id=1; requester 3 requesting meanwhile sees s_ready[3]=0.
- Reset mid-grant. Assert rst during GRANT for id 2.
  - Required: immediately busy=0, s_ready=0, p_valid=0.
  - Required: first grant after release goes to the lowest requesting id starting from 0.

Source files
------------

// File: rtl/data_c_shift_arbiter_if.sv
// Bundle between the arbiter, its requesters, the shared shift pipe and the result consumers.
// Every channel is valid/ready: a beat moves on a clock edge where valid and ready are both high;
// a source holding valid keeps its beat stable until then, and ready may depend on valid.
interface data_c_shift_arbiter_if #(
    parameter int NUM     = 4,
    parameter int DSIZE   = 8,
    parameter int IDSIZE  = $clog2(NUM),
    parameter int EX_SIZE = IDSIZE + 1
);
    logic [NUM-1:0]       s_valid;
    logic [NUM*DSIZE-1:0] s_data;
    logic [NUM-1:0]       s_last;
    logic [NUM-1:0]       s_ready;

    logic                 p_valid;
    logic [DSIZE-1:0]     p_data;
    logic [EX_SIZE-1:0]   p_ex;
    logic                 p_ready;

    logic                 r_valid;
    logic [DSIZE-1:0]     r_data;
    logic [EX_SIZE-1:0]   r_ex;
    logic                 r_ready;

    logic [NUM-1:0]       m_valid;
    logic [DSIZE-1:0]     m_data;
    logic                 m_last;
    logic [NUM-1:0]       m_ready;

    modport master (
        input  s_valid, s_data, s_last, p_ready, r_valid, r_data, r_ex, m_ready,
        output s_ready, p_valid, p_data, p_ex, r_ready, m_valid, m_data, m_last
    );

    modport slave (
        output s_valid, s_data, s_last, p_ready, r_valid, r_data, r_ex, m_ready,
        input  s_ready, p_valid, p_data, p_ex, r_ready, m_valid, m_data, m_last
    );
endinterface

// File: rtl/data_c_shift_arbiter.sv
// Packet-level round-robin sharing of one right-shift pipe; each packet is followed by a zero
// flush beat and returning beats are steered to their owner by the id carried on ex.
module data_c_shift_arbiter #(
    parameter int NUM     = 4,
    parameter int DSIZE   = 8,
    parameter int IDSIZE  = $clog2(NUM),
    parameter int EX_SIZE = IDSIZE + 1
) (
    input  logic                   clock,
    input  logic                   rst,
    data_c_shift_arbiter_if.master bus,
    output logic                   busy,
    output logic [IDSIZE-1:0]      cur_id,
    output logic [1:0]             o_dbg_state
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t            r_state;
    logic [IDSIZE-1:0] r_cur_id;
    logic [IDSIZE-1:0] r_rr_ptr;

    logic              w_any;
    logic [IDSIZE-1:0] w_pick;
    int                w_idx;
    logic [IDSIZE-1:0] w_sel;
    logic [DSIZE-1:0]  w_cur_data;
    logic [IDSIZE-1:0] w_rid;
    logic              w_rid_ok;

    // Walk from the farthest candidate back to rr_ptr+1 so the nearest asserted one wins.
    always_comb begin
        w_any  = |bus.s_valid;
        w_pick = '0;
        w_idx  = 0;
        w_sel  = '0;
        for (int k = NUM; k >= 1; k--) begin
            w_idx = (int'(r_rr_ptr) + k) % NUM;
            w_sel = w_idx[IDSIZE-1:0];
            if (bus.s_valid[w_sel]) w_pick = w_sel;
        end
    end

    assign w_cur_data = bus.s_data[int'(r_cur_id)*DSIZE +: DSIZE];

    always_comb begin
        bus.s_ready = '0;
        bus.p_valid = 1'b0;
        bus.p_data  = '0;
        bus.p_ex    = '0;
        case (r_state)
            GRANT: begin
                bus.p_valid           = bus.s_valid[r_cur_id];
                bus.p_data            = w_cur_data;
                bus.p_ex              = {1'b0, r_cur_id};
                bus.s_ready[r_cur_id] = bus.p_ready;
            end
            FLUSH: begin
                bus.p_valid = 1'b1;
                bus.p_ex    = {1'b1, r_cur_id};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cur_id <= '0;
            r_rr_ptr <= IDSIZE'(NUM - 1);
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_cur_id <= w_pick;
                        r_rr_ptr <= w_pick;
                        r_state  <= GRANT;
                    end
                end
                // The packet stays locked to cur_id even while its requester goes quiet.
                GRANT: begin
                    if (bus.s_valid[r_cur_id] && bus.p_ready && bus.s_last[r_cur_id])
                        r_state <= FLUSH;
                end
                FLUSH: begin
                    if (bus.p_ready) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy        = (r_state != IDLE);
    assign cur_id      = r_cur_id;
    assign o_dbg_state = r_state;

    // An id with no owner stalls the return path instead of dropping the beat.
    assign w_rid    = bus.r_ex[IDSIZE-1:0];
    assign w_rid_ok = (int'(w_rid) < NUM);

    always_comb begin
        bus.m_valid = '0;
        for (int i = 0; i < NUM; i++) bus.m_valid[i] = bus.r_valid && (int'(w_rid) == i);
        bus.r_ready = w_rid_ok ? bus.m_ready[w_rid] : 1'b0;
    end

    assign bus.m_data = bus.r_data;
    assign bus.m_last = bus.r_ex[IDSIZE];

    a_p_valid_hold: assert property (@(posedge clock) disable iff (rst)
        (bus.p_valid && !bus.p_ready) |=> bus.p_valid);
    a_s_ready_onehot: assert property (@(posedge clock) disable iff (rst)
        $onehot0(bus.s_ready));
    a_r_id_range: assert property (@(posedge clock) disable iff (rst)
        bus.r_valid |-> w_rid_ok);
endmodule

// File: tb/tb_data_c_shift_arbiter.sv
// Directed bench for data_c_shift_arbiter with a one-stage, one-bit right-shift pipe model.
module tb_data_c_shift_arbiter;
  localparam int NUM = 4;
  localparam int DSIZE = 8;
  localparam int IDSIZE = 2;
  localparam int EX_SIZE = 3;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  logic clock = 1'b0;
  logic rst = 1'b1;
  logic busy;
  logic [IDSIZE-1:0] cur_id;
  logic [1:0] dbg_state;
  logic p_hold = 1'b0;
  int errors = 0;
  int checks = 0;

  data_c_shift_arbiter_if #(.NUM(NUM), .DSIZE(DSIZE)) bus ();

  data_c_shift_arbiter #(.NUM(NUM), .DSIZE(DSIZE)) dut (
    .clock(clock),
    .rst(rst),
    .bus(bus.master),
    .busy(busy),
    .cur_id(cur_id),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  // ---------------- requester drivers ----------------
  logic [DSIZE:0] src_q [NUM][$];  // {last, data}

  always @(negedge clock) begin
    for (int i = 0; i < NUM; i++) begin
      logic [DSIZE:0] h;
      if (src_q[i].size() > 0) begin
        h = src_q[i][0];
        bus.s_valid[i] = 1'b1;
        bus.s_last[i] = h[DSIZE];
        bus.s_data[i*DSIZE +: DSIZE] = h[DSIZE-1:0];
      end else begin
        bus.s_valid[i] = 1'b0;
        bus.s_last[i] = 1'b0;
        bus.s_data[i*DSIZE +: DSIZE] = '0;
      end
    end
  end

  always @(posedge clock) begin
    for (int i = 0; i < NUM; i++)
      if (!rst && bus.s_valid[i] && bus.s_ready[i] && src_q[i].size() > 0)
        void'(src_q[i].pop_front());
  end

  // ---------------- pipe model: one stage, shifts right by one bit ----------------
  logic pv;
  logic [DSIZE-1:0] pd;
  logic [EX_SIZE-1:0] pe;
  logic res;

  assign bus.p_ready = (!pv || bus.r_ready) && !p_hold;
  assign bus.r_valid = pv;
  assign bus.r_data = pd;
  assign bus.r_ex = pe;

  always @(posedge clock or posedge rst) begin
    if (rst) begin
      pv <= 1'b0;
      pd <= '0;
      pe <= '0;
      res <= 1'b0;
    end else if (bus.p_valid && bus.p_ready) begin
      pv <= 1'b1;
      pd <= {res, bus.p_data[DSIZE-1:1]};
      pe <= bus.p_ex;
      res <= bus.p_data[0];
    end else if (bus.r_ready) begin
      pv <= 1'b0;
    end
  end

  // ---------------- observation logs ----------------
  logic [EX_SIZE+DSIZE-1:0] pin_q[$];   // {p_ex, p_data}
  logic [NUM+DSIZE:0] ret_q[$];         // {m_valid, m_last, m_data}
  logic [IDSIZE-1:0] grant_q[$];        // id of each flush beat accepted

  always @(posedge clock) begin
    if (!rst) begin
      if (bus.p_valid && bus.p_ready) begin
        pin_q.push_back({bus.p_ex, bus.p_data});
        if (bus.p_ex[IDSIZE]) grant_q.push_back(bus.p_ex[IDSIZE-1:0]);
      end
      if (bus.r_valid && bus.r_ready) ret_q.push_back({bus.m_valid, bus.m_last, bus.m_data});
    end
  end

  task automatic clear_logs();
    pin_q.delete();
    ret_q.delete();
    grant_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    p_hold = 1'b0;
    bus.m_ready = '1;
    for (int i = 0; i < NUM; i++) src_q[i].delete();
    clear_logs();
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0d want 0", busy); end
    checks++; if (cur_id !== 2'd0) begin errors++; $display("FAIL reset_cur_id: got %0d want 0", cur_id); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE); end
    checks++; if (bus.s_ready !== 4'b0000) begin errors++; $display("FAIL reset_s_ready: got %b want 0000", bus.s_ready); end
    checks++; if (bus.p_valid !== 1'b0) begin errors++; $display("FAIL reset_p_valid: got %0d want 0", bus.p_valid); end
    checks++; if (bus.p_data !== 8'h00) begin errors++; $display("FAIL reset_p_data: got %h want 00", bus.p_data); end
    checks++; if (bus.p_ex !== 3'b000) begin errors++; $display("FAIL reset_p_ex: got %b want 000", bus.p_ex); end
    checks++; if (bus.m_valid !== 4'b0000) begin errors++; $display("FAIL reset_m_valid: got %b want 0000", bus.m_valid); end
    rst = 1'b0;
    bus.m_ready = '1;
    step();
    step();
    checks++; if ({busy, dbg_state} !== {1'b0, ST_IDLE}) begin errors++; $display("FAIL reset_idle_after_release: got busy=%0d state=%0d want 0/0", busy, dbg_state); end
  endtask

  task automatic test_basic();
    logic [EX_SIZE+DSIZE-1:0] exp_pin[3] = '{11'h081, 11'h002, 11'h400};
    logic [NUM+DSIZE:0] exp_ret[3] = '{13'h0240, 13'h0281, 13'h0300};
    logic [NUM+DSIZE:0] got;
    clear_logs();
    src_q[0].push_back({1'b0, 8'h81});
    src_q[0].push_back({1'b1, 8'h02});
    for (int c = 0; c < 60 && ret_q.size() < 3; c++) step();
    checks++; if (pin_q.size() != 3) begin errors++; $display("FAIL basic_pin_count: got %0d want 3", pin_q.size()); end
    checks++; if (ret_q.size() != 3) begin errors++; $display("FAIL basic_ret_count: got %0d want 3", ret_q.size()); end
    for (int i = 0; i < 3; i++) begin
      got = (i < pin_q.size()) ? {2'b00, pin_q[i]} : 'x;
      checks++; if (got[10:0] !== exp_pin[i]) begin errors++; $display("FAIL basic_pin[%0d]: got %h want %h", i, got[10:0], exp_pin[i]); end
      got = (i < ret_q.size()) ? ret_q[i] : 'x;
      checks++; if (got !== exp_ret[i]) begin errors++; $display("FAIL basic_ret[%0d]: got %h want %h", i, got, exp_ret[i]); end
    end
  endtask

  task automatic test_round_robin();
    logic [IDSIZE-1:0] exp_g[5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd3};
    logic [NUM+DSIZE:0] exp_ret[10] = '{13'h0408, 13'h0580, 13'h0811, 13'h0900, 13'h1019,
                                        13'h1180, 13'h0222, 13'h0300, 13'h1002, 13'h1180};
    do_reset();
    src_q[1].push_back({1'b1, 8'h11});
    src_q[2].push_back({1'b1, 8'h22});
    src_q[3].push_back({1'b1, 8'h33});
    for (int c = 0; c < 100 && ret_q.size() < 6; c++) step();
    src_q[0].push_back({1'b1, 8'h44});
    src_q[3].push_back({1'b1, 8'h05});
    for (int c = 0; c < 100 && ret_q.size() < 10; c++) step();
    checks++; if (grant_q.size() != 5) begin errors++; $display("FAIL rr_grant_count: got %0d want 5", grant_q.size()); end
    checks++; if (ret_q.size() != 10) begin errors++; $display("FAIL rr_ret_count: got %0d want 10", ret_q.size()); end
    for (int i = 0; i < 5; i++) begin
      logic [IDSIZE-1:0] g;
      g = (i < grant_q.size()) ? grant_q[i] : 'x;
      checks++; if (g !== exp_g[i]) begin errors++; $display("FAIL rr_grant[%0d]: got %0d want %0d", i, g, exp_g[i]); end
    end
    for (int i = 0; i < 10; i++) begin
      logic [NUM+DSIZE:0] r;
      r = (i < ret_q.size()) ? ret_q[i] : 'x;
      checks++; if (r !== exp_ret[i]) begin errors++; $display("FAIL rr_ret[%0d]: got %h want %h", i, r, exp_ret[i]); end
    end
  endtask

  task automatic test_flush_backpressure();
    logic [EX_SIZE+DSIZE-1:0] p1;
    clear_logs();
    src_q[2].push_back({1'b1, 8'h07});
    for (int c = 0; c < 50 && dbg_state !== ST_FLUSH; c++) step();
    checks++; if (dbg_state !== ST_FLUSH) begin errors++; $display("FAIL fbp_reach_flush: got state %0d want %0d", dbg_state, ST_FLUSH); end
    p_hold = 1'b1;
    src_q[0].push_back({1'b1, 8'h09});
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if ({bus.p_valid, bus.p_data, bus.p_ex, bus.s_ready, dbg_state} !== {1'b1, 8'h00, 3'b110, 4'b0000, ST_FLUSH}) begin
        errors++;
        $display("FAIL fbp_hold[%0d]: got v=%0d d=%h ex=%b s_ready=%b st=%0d want 1 00 110 0000 %0d",
                 c, bus.p_valid, bus.p_data, bus.p_ex, bus.s_ready, dbg_state, ST_FLUSH);
      end
    end
    p_hold = 1'b0;
    for (int c = 0; c < 80 && !(grant_q.size() >= 2 && !busy && !bus.r_valid); c++) step();
    checks++; if (pin_q.size() != 4) begin errors++; $display("FAIL fbp_pin_count: got %0d want 4", pin_q.size()); end
    p1 = (pin_q.size() > 1) ? pin_q[1] : 'x;
    checks++; if (p1 !== 11'h600) begin errors++; $display("FAIL fbp_flush_beat: got %h want 600", p1); end
    checks++; if (grant_q.size() < 2 || grant_q[0] !== 2'd2 || grant_q[1] !== 2'd0) begin
      errors++; $display("FAIL fbp_grant_order: got %0d entries want 2 then 0", grant_q.size());
    end
  endtask

  task automatic test_output_backpressure();
    logic [NUM+DSIZE:0] r0, r2;
    clear_logs();
    bus.m_ready = 4'b1011;
    src_q[2].push_back({1'b0, 8'h10});
    src_q[2].push_back({1'b1, 8'h20});
    for (int c = 0; c < 50 && !bus.r_valid; c++) step();
    checks++; if (bus.r_valid !== 1'b1) begin errors++; $display("FAIL obp_r_valid: got %0d want 1", bus.r_valid); end
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if ({bus.r_ready, bus.m_valid, bus.m_last, bus.m_data, bus.p_ready, bus.s_ready, cur_id}
          !== {1'b0, 4'b0100, 1'b0, 8'h08, 1'b0, 4'b0000, 2'd2}) begin
        errors++;
        $display("FAIL obp_stall[%0d]: got r_ready=%0d m_valid=%b m_last=%0d m_data=%h p_ready=%0d s_ready=%b id=%0d want 0 0100 0 08 0 0000 2",
                 c, bus.r_ready, bus.m_valid, bus.m_last, bus.m_data, bus.p_ready, bus.s_ready, cur_id);
      end
    end
    bus.m_ready = '1;
    for (int c = 0; c < 60 && !(ret_q.size() >= 3 && !busy); c++) step();
    checks++; if (ret_q.size() != 3) begin errors++; $display("FAIL obp_ret_count: got %0d want 3", ret_q.size()); end
    r0 = (ret_q.size() > 0) ? ret_q[0] : 'x;
    r2 = (ret_q.size() > 2) ? ret_q[2] : 'x;
    checks++; if (r0 !== 13'h0808) begin errors++; $display("FAIL obp_ret0: got %h want 0808", r0); end
    checks++; if (r2 !== 13'h0900) begin errors++; $display("FAIL obp_ret2: got %h want 0900", r2); end
  endtask

  task automatic test_mid_packet();
    logic [NUM+DSIZE:0] r1;
    clear_logs();
    src_q[1].push_back({1'b0, 8'h55});
    for (int c = 0; c < 50 && src_q[1].size() != 0; c++) step();
    src_q[3].push_back({1'b1, 8'h0A});
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if ({cur_id, dbg_state, busy, bus.s_ready[3], bus.p_valid} !== {2'd1, ST_GRANT, 1'b1, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL mid_gap[%0d]: got id=%0d st=%0d busy=%0d s_ready3=%0d p_valid=%0d want 1 %0d 1 0 0",
                 c, cur_id, dbg_state, busy, bus.s_ready[3], bus.p_valid, ST_GRANT);
      end
    end
    src_q[1].push_back({1'b1, 8'h66});
    for (int c = 0; c < 80 && !(grant_q.size() >= 2 && ret_q.size() >= 5 && !busy); c++) step();
    checks++; if (grant_q.size() < 2 || grant_q[0] !== 2'd1 || grant_q[1] !== 2'd3) begin
      errors++; $display("FAIL mid_grant_order: got %0d entries want 1 then 3", grant_q.size());
    end
    r1 = (ret_q.size() > 1) ? ret_q[1] : 'x;
    checks++; if (r1 !== 13'h04B3) begin errors++; $display("FAIL mid_ret1: got %h want 04b3", r1); end
  endtask

  task automatic test_reset_mid();
    logic [IDSIZE-1:0] g0;
    clear_logs();
    p_hold = 1'b1;
    src_q[2].push_back({1'b0, 8'h01});
    for (int c = 0; c < 50 && !(dbg_state === ST_GRANT && cur_id === 2'd2); c++) step();
    checks++; if ({dbg_state, cur_id} !== {ST_GRANT, 2'd2}) begin errors++; $display("FAIL rstm_reach_grant: got st=%0d id=%0d want %0d 2", dbg_state, cur_id, ST_GRANT); end
    src_q[1].push_back({1'b1, 8'h31});
    src_q[3].push_back({1'b1, 8'h13});
    step();
    step();
    rst = 1'b1;
    #1;
    checks++; if ({busy, bus.s_ready, bus.p_valid, dbg_state} !== {1'b0, 4'b0000, 1'b0, ST_IDLE}) begin
      errors++; $display("FAIL rstm_immediate: got busy=%0d s_ready=%b p_valid=%0d st=%0d want 0 0000 0 0", busy, bus.s_ready, bus.p_valid, dbg_state);
    end
    src_q[2].delete();
    clear_logs();
    p_hold = 1'b0;
    step();
    step();
    rst = 1'b0;
    for (int c = 0; c < 80 && !(grant_q.size() >= 2 && !busy); c++) step();
    g0 = (grant_q.size() > 0) ? grant_q[0] : 'x;
    checks++; if (g0 !== 2'd1) begin errors++; $display("FAIL rstm_first_grant: got %0d want 1", g0); end
    checks++; if (grant_q.size() != 2) begin errors++; $display("FAIL rstm_grant_count: got %0d want 2", grant_q.size()); end
  endtask

  initial begin
    bus.m_ready = '1;
    test_reset();
    test_basic();
    test_round_robin();
    test_flush_backpressure();
    test_output_backpressure();
    test_mid_packet();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
